cpu_exec_trace_monitor: RTL and testbench

//  Synthesizable run monitor for cpu_top, intended for on-chip bring-up.
//  - Counts cycles from reset release.
//  - Captures one {cycle, PC, IR} record per DECODE entry into a circular trace buffer of parametrised depth.
//  - Detects HALT and a watchdog timeout.
//  - Exposes a valid/ready drain port that software or a UART bridge reads after the run.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/trace_ring_buffer.sv | 69 ++++++
 rtl/cpu_exec_trace_monitor.sv | 110 +++++++++++
 tb/tb_cpu_exec_trace_monitor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared cpu_top encodings and trace record layout for the run monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // cpu_top FSM encodings the monitor cares about
  localparam logic [2:0] ST_DECODE  = 3'b010;
  localparam logic [2:0] ST_EXECUTE = 3'b011;

  // Monitor run state; HALTED and TIMEOUT are terminal until reset
  typedef enum logic [1:0] {
    MON_RUN     = 2'd0,
    MON_HALTED  = 2'd1,
    MON_TIMEOUT = 2'd2
  } mon_state_e;

  // Trace record layout, LSB first: {cycle, pc, ir}
  function automatic int trace_ir_lsb();
    return 0;
  endfunction

  function automatic int trace_pc_lsb(input int ir_w);
    return ir_w;
  endfunction

  function automatic int trace_cyc_lsb(input int pc_w, input int ir_w);
    return pc_w + ir_w;
  endfunction

  function automatic int trace_rec_w(input int cyc_w, input int pc_w, input int ir_w);
    return cyc_w + pc_w + ir_w;
  endfunction

endpackage

// File: rtl/trace_ring_buffer.sv
// Circular record store: oldest record on rd_data, overwrite-oldest or drop-new when full.
// Latency: a write is visible on rd_data/entries one cycle later; rd_data itself is combinational.
// Backpressure: rd_valid/rd_ready pop; a simultaneous pop frees a slot so a full write is never lost.
module trace_ring_buffer #(
  parameter int DEPTH        = 16,
  parameter int WIDTH        = 56,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   entries,
  output logic                     overflow_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop;
  logic             do_write;
  logic             adv_rd;

  // Decide per cycle whether storage is written and whether the oldest slot retires
  always_comb begin
    full           = (entries == CNT_W'(DEPTH));
    rd_valid       = (entries != '0);
    rd_data        = mem[rd_ptr];
    pop            = rd_valid && rd_ready;
    // A pop makes room, so only a full buffer without a pop can lose data
    overflow_pulse = wr_en && full && !pop;
    do_write       = wr_en && (pop || !full || (STOP_ON_FULL == 0));
    // Overwrite mode retires the oldest record to make room for the new one
    adv_rd         = pop || (overflow_pulse && (STOP_ON_FULL == 0));
  end

  // Storage, pointers and occupancy; all cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      entries <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_write) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (adv_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_write && !adv_rd) begin
        entries <= entries + CNT_W'(1);
      end else if (adv_rd && !do_write) begin
        entries <= entries - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_exec_trace_monitor.sv
// Bring-up run monitor for cpu_top: cycle/insn counters, DECODE-entry trace, halt and watchdog.
// Latency: a DECODE entry is stored at the next edge; halted/timed_out rise the cycle after the trigger.
// Backpressure: drain via rd_valid/rd_ready at any time; capture never stalls the CPU.
module cpu_exec_trace_monitor
  import cpu_pkg::*;
#(
  parameter int PC_W         = 8,
  parameter int IR_W         = 16,
  parameter int CYC_W        = 32,
  parameter int DEPTH        = 16,
  parameter int TIMEOUT      = 1000000,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  cpu_state,
  input  logic [PC_W-1:0]             cpu_pc,
  input  logic [IR_W-1:0]             cpu_ir,
  input  logic                        cpu_halt,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [CYC_W+PC_W+IR_W-1:0]  rd_data,
  output logic [$clog2(DEPTH):0]      entries,
  output logic [CYC_W-1:0]            cycle_count,
  output logic [CYC_W-1:0]            insn_count,
  output logic                        halted,
  output logic                        timed_out,
  output logic                        overflow
);

  localparam int              REC_W        = trace_rec_w(CYC_W, PC_W, IR_W);
  localparam logic [CYC_W-1:0] CYC_MAX      = '1;
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT - 1);

  mon_state_e       state_q;
  mon_state_e       state_d;
  logic [2:0]       prev_state;
  logic             running;
  logic             capture;
  logic             ovf_pulse;
  logic [REC_W-1:0] wr_data;

  // Run state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MON_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and decoded status; halt beats the watchdog when both fire together
  always_comb begin
    state_d   = state_q;
    running   = (state_q == MON_RUN);
    halted    = (state_q == MON_HALTED);
    timed_out = (state_q == MON_TIMEOUT);
    capture   = running && (cpu_state == ST_DECODE) && (prev_state != ST_DECODE);
    wr_data   = {cycle_count, cpu_pc, cpu_ir};
    case (state_q)
      MON_RUN: begin
        if (cpu_halt) begin
          state_d = MON_HALTED;
        end else if (cycle_count == TIMEOUT_LAST) begin
          state_d = MON_TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Saturating counters, DECODE edge history and sticky overflow.
  // The cycle on which halt is seen does not count, so cycle_count ends on the halt cycle's value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      insn_count  <= '0;
      prev_state  <= '0;
      overflow    <= 1'b0;
    end else begin
      prev_state <= cpu_state;
      if (running && !cpu_halt && (cycle_count != CYC_MAX)) begin
        cycle_count <= cycle_count + CYC_W'(1);
      end
      if (capture && (insn_count != CYC_MAX)) begin
        insn_count <= insn_count + CYC_W'(1);
      end
      if (ovf_pulse) begin
        overflow <= 1'b1;
      end
    end
  end

  trace_ring_buffer #(
    .DEPTH        (DEPTH),
    .WIDTH        (REC_W),
    .STOP_ON_FULL (STOP_ON_FULL)
  ) u_ring (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (capture),
    .wr_data        (wr_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .entries        (entries),
    .overflow_pulse (ovf_pulse)
  );

endmodule

// File: tb/tb_cpu_exec_trace_monitor.sv
// Bench for cpu_exec_trace_monitor: two instances (overwrite / drop-new), DEPTH=4, TIMEOUT=50.
// Latency: model advances at each posedge, outputs compared 1 time unit later.
// Backpressure: a single shared rd_ready drives both instances.
module tb_cpu_exec_trace_monitor;
  import cpu_pkg::*;

  localparam int D = 4;

  logic        clk;
  logic        reset;
  logic [2:0]  cpu_state;
  logic [7:0]  cpu_pc;
  logic [15:0] cpu_ir;
  logic        cpu_halt;
  logic        rd_ready;

  logic        rd_valid    [2];
  logic [55:0] rd_data     [2];
  logic [2:0]  entries     [2];
  logic [31:0] cycle_count [2];
  logic [31:0] insn_count  [2];
  logic        halted      [2];
  logic        timed_out   [2];
  logic        overflow    [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: per instance a run state, counters and an ordered list (index 0 = oldest)
  int          m_st   [2];
  logic [31:0] m_cyc  [2];
  logic [31:0] m_insn [2];
  logic [2:0]  m_prev [2];
  logic [55:0] m_buf  [2][D];
  int          m_n    [2];
  logic        m_ovf  [2];

  cpu_exec_trace_monitor #(.PC_W(8), .IR_W(16), .CYC_W(32), .DEPTH(D), .TIMEOUT(50), .STOP_ON_FULL(0)) u0 (
    .clk(clk), .reset(reset), .cpu_state(cpu_state), .cpu_pc(cpu_pc), .cpu_ir(cpu_ir),
    .cpu_halt(cpu_halt), .rd_valid(rd_valid[0]), .rd_ready(rd_ready), .rd_data(rd_data[0]),
    .entries(entries[0]), .cycle_count(cycle_count[0]), .insn_count(insn_count[0]),
    .halted(halted[0]), .timed_out(timed_out[0]), .overflow(overflow[0]));

  cpu_exec_trace_monitor #(.PC_W(8), .IR_W(16), .CYC_W(32), .DEPTH(D), .TIMEOUT(50), .STOP_ON_FULL(1)) u1 (
    .clk(clk), .reset(reset), .cpu_state(cpu_state), .cpu_pc(cpu_pc), .cpu_ir(cpu_ir),
    .cpu_halt(cpu_halt), .rd_valid(rd_valid[1]), .rd_ready(rd_ready), .rd_data(rd_data[1]),
    .entries(entries[1]), .cycle_count(cycle_count[1]), .insn_count(insn_count[1]),
    .halted(halted[1]), .timed_out(timed_out[1]), .overflow(overflow[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d: got %0h want %0h (cyc %0d)", name, i, act, exp, cyc);
    end
  endtask

  // Advance the model one clock using the inputs sampled at that edge
  task automatic model_step();
    logic [55:0] rec;
    bit          cap;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_st[i] = 0; m_cyc[i] = '0; m_insn[i] = '0; m_prev[i] = '0; m_n[i] = 0; m_ovf[i] = 1'b0;
      end else begin
        rec = {m_cyc[i], cpu_pc, cpu_ir};
        cap = (m_st[i] == 0) && (cpu_state == ST_DECODE) && (m_prev[i] != ST_DECODE);
        if (m_n[i] > 0 && rd_ready) begin
          for (int k = 0; k < D - 1; k++) m_buf[i][k] = m_buf[i][k+1];
          m_n[i]--;
        end
        if (cap) begin
          if (m_insn[i] != 32'hFFFF_FFFF) m_insn[i]++;
          if (m_n[i] < D) begin
            m_buf[i][m_n[i]] = rec; m_n[i]++;
          end else begin
            m_ovf[i] = 1'b1;
            if (i == 0) begin
              for (int k = 0; k < D - 1; k++) m_buf[i][k] = m_buf[i][k+1];
              m_buf[i][D-1] = rec;
            end
          end
        end
        if (m_st[i] == 0) begin
          if (cpu_halt) m_st[i] = 1;
          else begin
            if (m_cyc[i] == 32'd49) m_st[i] = 2;
            if (m_cyc[i] != 32'hFFFF_FFFF) m_cyc[i]++;
          end
        end
        m_prev[i] = cpu_state;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk("rd_valid", i, 64'(rd_valid[i]), 64'(m_n[i] > 0));
      chk("entries", i, 64'(entries[i]), 64'(m_n[i]));
      if (m_n[i] > 0) chk("rd_data", i, 64'(rd_data[i]), 64'(m_buf[i][0]));
      chk("cycle_count", i, 64'(cycle_count[i]), 64'(m_cyc[i]));
      chk("insn_count", i, 64'(insn_count[i]), 64'(m_insn[i]));
      chk("halted", i, 64'(halted[i]), 64'(m_st[i] == 1));
      chk("timed_out", i, 64'(timed_out[i]), 64'(m_st[i] == 2));
      chk("overflow", i, 64'(overflow[i]), 64'(m_ovf[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic run_cycle(input logic [2:0] st, input logic [7:0] pc, input logic [15:0] ir, input logic h);
    cpu_state = st; cpu_pc = pc; cpu_ir = ir; cpu_halt = h;
    tick();
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; rd_ready = 1'b0;
    cpu_state = 3'd0; cpu_pc = '0; cpu_ir = '0; cpu_halt = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int exp0 [4];
    int exp1 [4];
    exp0 = '{10, 14, 18, 22};
    exp1 = '{2, 6, 10, 14};
    reset = 1'b1; rd_ready = 1'b0;
    cpu_state = 3'd0; cpu_pc = '0; cpu_ir = '0; cpu_halt = 1'b0;
    @(negedge clk);

    // 1: DECODE held 3 cycles right after reset -> exactly one record {0,00,1234}
    do_reset(5);
    for (int k = 0; k < 3; k++) run_cycle(ST_DECODE, 8'h00, 16'h1234, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("t1_entries", i, 64'(entries[i]), 64'd1);
      chk("t1_insn", i, 64'(insn_count[i]), 64'd1);
      chk("t1_record", i, 64'(rd_data[i]), 64'({32'd0, 8'h00, 16'h1234}));
    end

    // 2/3: six DECODE entries at cycles 2,6,...,22 into a 4-deep buffer
    do_reset(2);
    for (int c = 0; c < 26; c++)
      run_cycle(((c % 4 == 2) && (c <= 22)) ? ST_DECODE : ST_EXECUTE, 8'(c), 16'hA000 + 16'(c), 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("t2_entries", i, 64'(entries[i]), 64'd4);
      chk("t2_overflow", i, 64'(overflow[i]), 64'd1);
      chk("t2_insn", i, 64'(insn_count[i]), 64'd6);
    end
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain_cycle", 0, 64'(rd_data[0][55:24]), 64'(exp0[k]));
      chk("t3_drain_cycle", 1, 64'(rd_data[1][55:24]), 64'(exp1[k]));
      rd_ready = 1'b1;
      run_cycle(ST_EXECUTE, 8'h00, 16'h0000, 1'b0);
    end
    rd_ready = 1'b0;
    for (int i = 0; i < 2; i++) chk("t2_drained", i, 64'(rd_valid[i]), 64'd0);

    // 4: halt at cycle 40, then 100 cycles of DECODE toggling must not count or capture
    while (cyc < 40) run_cycle(ST_EXECUTE, 8'h00, 16'h0000, 1'b0);
    for (int i = 0; i < 2; i++) chk("t4_not_yet_halted", i, 64'(halted[i]), 64'd0);
    run_cycle(ST_EXECUTE, 8'h28, 16'h0000, 1'b1);
    for (int i = 0; i < 2; i++) chk("t4_halted_next", i, 64'(halted[i]), 64'd1);
    for (int k = 0; k < 100; k++) run_cycle((k % 2 == 0) ? ST_DECODE : ST_EXECUTE, 8'(k), 16'h5555, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("t4_cycle_frozen", i, 64'(cycle_count[i]), 64'd40);
      chk("t4_insn_frozen", i, 64'(insn_count[i]), 64'd6);
      chk("t4_no_capture", i, 64'(entries[i]), 64'd0);
      chk("t4_no_timeout", i, 64'(timed_out[i]), 64'd0);
    end

    // 5a: watchdog with no halt
    do_reset(2);
    repeat (60) run_cycle(ST_EXECUTE, 8'h00, 16'h0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("t5_timed_out", i, 64'(timed_out[i]), 64'd1);
      chk("t5_cycle", i, 64'(cycle_count[i]), 64'd50);
      chk("t5_not_halted", i, 64'(halted[i]), 64'd0);
    end

    // 5b: halt on the watchdog's last cycle wins
    do_reset(2);
    while (cyc < 49) run_cycle(ST_EXECUTE, 8'h00, 16'h0000, 1'b0);
    repeat (5) run_cycle(ST_EXECUTE, 8'h00, 16'h0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("t5b_halted", i, 64'(halted[i]), 64'd1);
      chk("t5b_timed_out", i, 64'(timed_out[i]), 64'd0);
      chk("t5b_cycle", i, 64'(cycle_count[i]), 64'd49);
    end

    // 6: full buffer, pop and capture together; then reset while rd_valid=1
    do_reset(2);
    for (int c = 0; c < 9; c++)
      run_cycle((c % 2 == 1) ? ST_DECODE : ST_EXECUTE, 8'(c), 16'hB000 + 16'(c), 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("t6_full", i, 64'(entries[i]), 64'd4);
      chk("t6_oldest", i, 64'(rd_data[i][55:24]), 64'd1);
    end
    rd_ready = 1'b1;
    run_cycle(ST_DECODE, 8'h09, 16'hB009, 1'b0);
    rd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t6_entries_kept", i, 64'(entries[i]), 64'd4);
      chk("t6_no_overflow", i, 64'(overflow[i]), 64'd0);
      chk("t6_next_oldest", i, 64'(rd_data[i][55:24]), 64'd3);
      chk("t6_insn", i, 64'(insn_count[i]), 64'd5);
    end
    reset = 1'b1;
    cpu_state = ST_EXECUTE;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("t6_rst_valid", i, 64'(rd_valid[i]), 64'd0);
      chk("t6_rst_cycle", i, 64'(cycle_count[i]), 64'd0);
      chk("t6_rst_insn", i, 64'(insn_count[i]), 64'd0);
      chk("t6_rst_entries", i, 64'(entries[i]), 64'd0);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
